// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Brief    : Stall/flush sequencer for a 5-stage pipeline. Handles load-use
//             stalls, data-memory freezes and taken-branch flush windows,
//             and keeps saturating stall/flush event counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W     = 6,
  parameter int BRANCH_PENALTY = 2,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_valid,
  input  logic                  br_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  // Remaining flush cycles after the resolve cycle never exceed BRANCH_PENALTY-1.
  localparam int REM_W = (BRANCH_PENALTY > 1) ? $clog2(BRANCH_PENALTY) : 1;
  localparam logic [REM_W-1:0] REM_INIT =
      (BRANCH_PENALTY > 1) ? REM_W'(BRANCH_PENALTY - 1) : '0;
  localparam logic [REM_W-1:0] REM_ONE = REM_W'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [REM_W-1:0] remain_q, remain_d;
  logic             pend_br_q, pend_br_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic lu_hazard;
  logic flush_event;

  // A load in EX whose destination feeds the instruction in ID must stall one cycle.
  always_comb begin
    lu_hazard = ex_valid & ex_mem_read &
                ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

  // Next-state and Mealy control outputs; reset forces a safe NOP-injecting pattern.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    pend_br_d   = pend_br_q;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    flush_event = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (dmem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
          if (br_taken) pend_br_d = 1'b1;
          state_d = ST_MEM_WAIT;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          flush_event = 1'b1;
          if (BRANCH_PENALTY > 1) begin
            remain_d = REM_INIT;
            state_d  = ST_FLUSH;
          end
        end else if (lu_hazard) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        if (dmem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
          if (br_taken) pend_br_d = 1'b1;
        end else begin
          // A branch that resolved while frozen is acted on now.
          pend_br_d = 1'b0;
          state_d   = ST_RUN;
          if (pend_br_q | br_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            flush_event = 1'b1;
            if (BRANCH_PENALTY > 1) begin
              remain_d = REM_INIT;
              state_d  = ST_FLUSH;
            end
          end else if (lu_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        if (dmem_busy) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          exmem_hold = 1'b1;
        end else begin
          // Only wrong-path instructions remain, so branch/hazard inputs are ignored.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          remain_d    = remain_q - REM_ONE;
          if (remain_q == REM_ONE) state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase

    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_hold  = 1'b0;
      flush_event = 1'b0;
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (!pc_write && (stall_count_q != {CNT_W{1'b1}}))
      stall_count_d = stall_count_q + CNT_W'(1);
    if (flush_event && (flush_count_q != {CNT_W{1'b1}}))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      remain_q      <= '0;
      pend_br_q     <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      remain_q      <= remain_d;
      pend_br_q     <= pend_br_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule
`default_nettype wire
